// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register of the RV32I core. It captures the MEM-stage
// results, aligns and sign/zero-extends load data on the way in, and presents
// four writeback candidates to the downstream writeback mux:
//   i0 = alu_result_o, i1 = load_data_o, i2 = pc_plus4_o, i3 = imm_o,
//   with sel = result_src_o.
// It also counts retired instructions for the performance counters.
//
// Optional feature macro: MEM_WB_MISALIGN_CHECK_EN
//   When defined, the block adds the output misalign_o. This output flags
//   misaligned LH/LHU/LW loads. While it is set, the register-file write is
//   suppressed.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   stall_i               hold the current WB contents
//   flush_i               capture a bubble (has priority over stall_i)
//   valid_i .. imm_i      MEM-stage instruction fields
//   valid_o .. imm_o      registered WB-stage fields
//   reg_write_o           qualified register-file write enable
//   load_data_o           aligned and extended load data
//   retire_cnt_o          retired-instruction count, wraps modulo 2^CNT_W
//   misalign_o            (macro only) misaligned-load flag
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             reg_write_i,
    input  logic [1:0]       result_src_i,
    input  logic [4:0]       rd_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      alu_result_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic [31:0]      pc_plus4_i,
    input  logic [31:0]      imm_i,
    output logic             valid_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [4:0]       rd_o,
    output logic [31:0]      alu_result_o,
    output logic [31:0]      load_data_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      imm_o,
    output logic [CNT_W-1:0] retire_cnt_o
`ifdef MEM_WB_MISALIGN_CHECK_EN
    ,
    output logic             misalign_o
`endif
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // ------------------------------------------------------------------
    // Load alignment (computed on the input side, before the register)
    // ------------------------------------------------------------------
    logic [1:0]  off;
    logic [7:0]  rdata_bytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_aligned;

    assign off = alu_result_i[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign rdata_bytes[gi] = mem_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rdata_bytes[off];
    // Halfword selection uses only off[1]. A misaligned LH therefore
    // silently reads the half containing the addressed byte.
    assign half_sel = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        load_aligned = mem_rdata_i;
        case (funct3_i)
            F3_LB:   load_aligned = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_aligned = {24'd0, byte_sel};
            F3_LH:   load_aligned = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_aligned = {16'd0, half_sel};
            default: load_aligned = mem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic             valid_q,     valid_d;
    logic             reg_q,       reg_d;
    logic [1:0]       src_q,       src_d;
    logic [4:0]       rd_q,        rd_d;
    logic [31:0]      alu_q,       alu_d;
    logic [31:0]      load_q,      load_d;
    logic [31:0]      pc4_q,       pc4_d;
    logic [31:0]      imm_q,       imm_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             mis_q,       mis_d;
    logic             mis_in;

`ifdef MEM_WB_MISALIGN_CHECK_EN
    always_comb begin
        mis_in = 1'b0;
        if (valid_i && (result_src_i == 2'd1)) begin
            if (((funct3_i == F3_LH) || (funct3_i == F3_LHU)) && off[0])
                mis_in = 1'b1;
            else if ((funct3_i == F3_LW) && (off != 2'd0))
                mis_in = 1'b1;
        end
    end
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        // Default: hold (stall behaviour)
        valid_d = valid_q;
        reg_d   = reg_q;
        src_d   = src_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        load_d  = load_q;
        pc4_d   = pc4_q;
        imm_d   = imm_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;

        // The instruction currently in WB retires whenever it is not being
        // held. A flush replaces what comes next. It does not cancel the
        // instruction that is leaving.
        if (valid_q && !stall_i)
            cnt_d = cnt_q + CNT_W'(1);

        if (flush_i) begin
            valid_d = 1'b0;
            reg_d   = 1'b0;
            src_d   = 2'd0;
            rd_d    = 5'd0;
            alu_d   = 32'd0;
            load_d  = 32'd0;
            pc4_d   = 32'd0;
            imm_d   = 32'd0;
            mis_d   = 1'b0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            reg_d   = reg_write_i;
            src_d   = result_src_i;
            rd_d    = rd_i;
            alu_d   = alu_result_i;
            load_d  = load_aligned;
            pc4_d   = pc_plus4_i;
            imm_d   = imm_i;
            mis_d   = mis_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            reg_q   <= 1'b0;
            src_q   <= 2'd0;
            rd_q    <= 5'd0;
            alu_q   <= 32'd0;
            load_q  <= 32'd0;
            pc4_q   <= 32'd0;
            imm_q   <= 32'd0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            reg_q   <= reg_d;
            src_q   <= src_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            load_q  <= load_d;
            pc4_q   <= pc4_d;
            imm_q   <= imm_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Writes to x0 are never issued. Misaligned loads never write.
    assign reg_write_o  = reg_q & valid_q & (rd_q != 5'd0) & ~mis_q;
    assign valid_o      = valid_q;
    assign result_src_o = src_q;
    assign rd_o         = rd_q;
    assign alu_result_o = alu_q;
    assign load_data_o  = load_q;
    assign pc_plus4_o   = pc4_q;
    assign imm_o        = imm_q;
    assign retire_cnt_o = cnt_q;
`ifdef MEM_WB_MISALIGN_CHECK_EN
    assign misalign_o   = mis_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed testbench for mem_wb_stage. A behavioural model of the WB
// register is compared against the DUT one time unit after every rising
// edge. Hand-computed literal expectations pin the load alignment, the
// retire count, the stall/flush behaviour and the reset behaviour.
//
// The counter width is reduced to 4 bits so that the wrap is exercised.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, flush, valid, regw;
    logic [1:0]       src;
    logic [4:0]       rd;
    logic [2:0]       f3;
    logic [31:0]      alu, rdata, pc4, imm;

    logic             valid_o, reg_write_o;
    logic [1:0]       result_src_o;
    logic [4:0]       rd_o;
    logic [31:0]      alu_result_o, load_data_o, pc_plus4_o, imm_o;
    logic [CNT_W-1:0] retire_cnt_o;
`ifdef MEM_WB_MISALIGN_CHECK_EN
    logic             misalign_o;
`endif

    int tests = 0;
    int fails = 0;
    int txn   = 0;

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .valid_i      (valid),
        .reg_write_i  (regw),
        .result_src_i (src),
        .rd_i         (rd),
        .funct3_i     (f3),
        .alu_result_i (alu),
        .mem_rdata_i  (rdata),
        .pc_plus4_i   (pc4),
        .imm_i        (imm),
        .valid_o      (valid_o),
        .reg_write_o  (reg_write_o),
        .result_src_o (result_src_o),
        .rd_o         (rd_o),
        .alu_result_o (alu_result_o),
        .load_data_o  (load_data_o),
        .pc_plus4_o   (pc_plus4_o),
        .imm_o        (imm_o),
        .retire_cnt_o (retire_cnt_o)
`ifdef MEM_WB_MISALIGN_CHECK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_value(input logic [2:0] fn,
                                               input logic [1:0] a,
                                               input logic [31:0] word);
        logic [31:0] b, h;
        b = word >> (8 * a);
        h = word >> (16 * a[1]);
        case (fn)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'd0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'd0, h[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic misaligned(input logic v, input logic [1:0] s,
                                        input logic [2:0] fn, input logic [1:0] a);
        if (!v || s != 2'd1) return 1'b0;
        if ((fn == 3'b001 || fn == 3'b101) && a[0]) return 1'b1;
        if (fn == 3'b010 && a != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    logic             m_valid, m_reg, m_mis;
    logic [1:0]       m_src;
    logic [4:0]       m_rd;
    logic [31:0]      m_alu, m_load, m_pc, m_imm;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_valid, m_reg, m_mis, m_src, m_rd} <= '0;
            {m_alu, m_load, m_pc, m_imm}         <= '0;
            m_cnt                                <= '0;
        end else begin
            if (m_valid && !stall) m_cnt <= m_cnt + 1'b1;
            if (flush) begin
                {m_valid, m_reg, m_mis, m_src, m_rd} <= '0;
                {m_alu, m_load, m_pc, m_imm}         <= '0;
            end else if (!stall) begin
                m_valid <= valid;
                m_reg   <= regw;
                m_src   <= src;
                m_rd    <= rd;
                m_alu   <= alu;
                m_load  <= load_value(f3, alu[1:0], rdata);
                m_pc    <= pc4;
                m_imm   <= imm;
`ifdef MEM_WB_MISALIGN_CHECK_EN
                m_mis   <= misaligned(valid, src, f3, alu[1:0]);
`else
                m_mis   <= 1'b0;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("m_valid",  valid_o,      m_valid);
            chk("m_regwr",  reg_write_o,  m_reg && m_valid && (m_rd != 0) && !m_mis);
            chk("m_src",    result_src_o, m_src);
            chk("m_rd",     rd_o,         m_rd);
            chk("m_alu",    alu_result_o, m_alu);
            chk("m_load",   load_data_o,  m_load);
            chk("m_pc4",    pc_plus4_o,   m_pc);
            chk("m_imm",    imm_o,        m_imm);
            chk("m_cnt",    retire_cnt_o, m_cnt);
`ifdef MEM_WB_MISALIGN_CHECK_EN
            chk("m_mis",    misalign_o,   m_mis);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic st, input logic fl, input logic v, input logic rw,
                       input logic [1:0] s, input logic [4:0] r, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d);
        stall = st; flush = fl; valid = v; regw = rw;
        src = s; rd = r; f3 = fn; alu = a; rdata = d;
        pc4 = 32'h0000_1000 + 32'(txn * 4);
        imm = a ^ 32'hA5A5_0000;
        @(negedge clk);
        $display("[TB] txn %0d stall=%0b flush=%0b valid=%0b rw=%0b src=%0d rd=%0d f3=%03b addr=%08h rdata=%08h -> valid_o=%0b we=%0b load=%08h cnt=%0d",
                 txn, st, fl, v, rw, s, r, fn, a, d, valid_o, reg_write_o, load_data_o, retire_cnt_o);
        txn++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 3'b000, 32'd0, 32'd0);
    endtask

    logic [2:0] f3_tab [6];

    initial begin
        rst = 1'b1;
        stall = 0; flush = 0; valid = 0; regw = 0; src = 0; rd = 0; f3 = 0;
        alu = 0; rdata = 0; pc4 = 0; imm = 0;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101; f3_tab[5] = 3'b011;

        repeat (2) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt",   retire_cnt_o, 0);
        rst = 1'b0;

        // LB / LBU, byte 3 of 0x80FF_7F01
        cyc(0, 0, 1, 1, 2'd1, 5'd1, 3'b000, 32'h0000_0003, 32'h80FF_7F01);
        chk("lb_off3",  load_data_o, 32'hFFFF_FF80);
        chk("cnt_t1",   retire_cnt_o, 0);
        cyc(0, 0, 1, 1, 2'd1, 5'd1, 3'b100, 32'h0000_0003, 32'h80FF_7F01);
        chk("lbu_off3", load_data_o, 32'h0000_0080);
        chk("cnt_t2",   retire_cnt_o, 1);
        // LH off 2 / LHU off 0 of 0x8001_1234
        cyc(0, 0, 1, 1, 2'd1, 5'd2, 3'b001, 32'h0000_0002, 32'h8001_1234);
        chk("lh_off2",  load_data_o, 32'hFFFF_8001);
        cyc(0, 0, 1, 1, 2'd1, 5'd2, 3'b101, 32'h0000_0000, 32'h8001_1234);
        chk("lhu_off0", load_data_o, 32'h0000_1234);
        chk("cnt_t4",   retire_cnt_o, 3);

        // ADD to x5, then stall three cycles with changing inputs
        cyc(0, 0, 1, 1, 2'd0, 5'd5, 3'b000, 32'h1234_5678, 32'd0);
        chk("add_cnt",  retire_cnt_o, 4);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 1, 2'd2, 5'(9 + i), 3'b010, 32'hCAFE_0000 + 32'(i), 32'hFFFF_FFFF);
            chk("stall_alu", alu_result_o, 32'h1234_5678);
            chk("stall_rd",  rd_o, 5);
            chk("stall_we",  reg_write_o, 1);
            chk("stall_cnt", retire_cnt_o, 4);
        end
        idle();
        chk("release_cnt", retire_cnt_o, 5);
        chk("release_vld", valid_o, 0);
        idle();
        chk("release_cnt2", retire_cnt_o, 5);

        // Flush together with stall captures a bubble
        cyc(0, 0, 1, 1, 2'd0, 5'd3, 3'b000, 32'h0000_0011, 32'd0);
        cyc(1, 1, 1, 1, 2'd0, 5'd4, 3'b000, 32'h0000_0022, 32'd0);
        chk("fs_valid", valid_o, 0);
        chk("fs_we",    reg_write_o, 0);
        chk("fs_rd",    rd_o, 0);
        // Flush alone still retires the leaving instruction
        cyc(0, 0, 1, 1, 2'd0, 5'd7, 3'b000, 32'h0000_0033, 32'd0);
        chk("pre_fl_cnt", retire_cnt_o, 5);
        cyc(0, 1, 1, 1, 2'd0, 5'd8, 3'b000, 32'h0000_0044, 32'd0);
        chk("fl_cnt",   retire_cnt_o, 6);
        chk("fl_valid", valid_o, 0);
        // Write to x0 is suppressed
        cyc(0, 0, 1, 1, 2'd0, 5'd0, 3'b000, 32'h0000_0055, 32'd0);
        chk("x0_we",    reg_write_o, 0);
        chk("x0_valid", valid_o, 1);

        // Misaligned LW
        cyc(0, 0, 1, 1, 2'd1, 5'd9, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF);
        chk("lw_cnt",   retire_cnt_o, 7);
`ifdef MEM_WB_MISALIGN_CHECK_EN
        chk("lw_mis",   misalign_o, 1);
        chk("lw_mis_we", reg_write_o, 0);
`else
        chk("lw_we",    reg_write_o, 1);
        chk("lw_data",  load_data_o, 32'hDEAD_BEEF);
`endif
        idle();
        chk("cnt_t17",  retire_cnt_o, 8);

        // Every load type at every offset, back to back (counter wraps)
        for (int k = 0; k < 6; k++) begin
            for (int o = 0; o < 4; o++) begin
                cyc(0, 0, 1, 1, 2'd1, 5'(k + 10), f3_tab[k], 32'h0000_2000 + 32'(o), 32'hF18C_7A05);
            end
        end
        chk("wrap_15",  retire_cnt_o, 15);
        idle();
        chk("wrap_0",   retire_cnt_o, 0);

        // Asynchronous reset between edges discards the in-flight instruction
        cyc(0, 0, 1, 1, 2'd3, 5'd6, 3'b000, 32'h0000_0077, 32'd0);
        chk("pre_rst_valid", valid_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_we",    reg_write_o, 0);
        chk("arst_rd",    rd_o, 0);
        chk("arst_imm",   imm_o, 0);
        chk("arst_alu",   alu_result_o, 0);
        chk("arst_cnt",   retire_cnt_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("post_rst_cnt", retire_cnt_o, 0);
        chk("post_rst_vld", valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
